noc_traffic_sequencer: RTL and testbench
========================================

# noc_traffic_sequencer

Run controller for the mesh traffic-generator PEs in the NoC testbench. It drives the shared `start` line and the per-PE `enableSend` lines, and watches each PE's `done` output. It runs injection either concurrently (all PEs at once) or serially (one PE at a time, in PE-number order), enforces a timeout, and holds a drain window before dropping `start`. Dropping `start` triggers the PEs' end-of-run reports.

## Interface
- `X`, default 4: mesh columns.
- `Y`, default 4: mesh rows. N = X*Y PEs; PE number = y*X + x.
- `PE_W`, default 4: width of the active-PE index; must satisfy 2^PE_W >= N.
- `CNT_W`, default 32: cycle-counter width.
- `DRAIN_CYCLES`, default 100: cycles between end of injection and `start` falling; must be >= 1.
- `TIMEOUT`, default 100000: maximum INJECT cycles; 0 disables the timeout.

Ports. One clock; reset is asynchronous and active-low.
- `clk`  in  1  clock.
- `rstn`  in  1  asynchronous active-low reset.
- `i_go`  in  1  run request; sampled only in IDLE.
- `i_mode`  in  1  0 = concurrent, 1 = serial; captured with `i_go`.
- `i_pe_done`  in  N  per-PE `done`; bit k = PE k.
- `o_start`  out  1  to all PEs' `start`.
- `o_enable_send`  out  N  per-PE `enableSend`.
- `o_busy`  out  1  high whenever state != IDLE.
- `o_run_done`  out  1  one-cycle pulse in FINISH.
- `o_timeout`  out  1  sticky; set when a run times out.
- `o_active_pe`  out  PE_W  PE currently enabled in serial mode; 0 in concurrent mode.
- `o_cycle_count`  out  CNT_W  INJECT cycles of the current or last run.

## Operation
- Reset (asynchronous, any state): state = IDLE, and every output, `finished[N-1:0]` and the drain counter go to 0.
- States:
  - IDLE: `o_start`=0, enables all 0. When `i_go`=1 at an edge: capture mode, clear `finished`, `o_cycle_count` and `o_timeout`, then go to INJECT. In concurrent mode set all enables to 1. In serial mode set only enable[0] and set `o_active_pe`=0.
  - INJECT: `o_start`=1. `o_cycle_count` increments every cycle and saturates at all-ones.
  - DRAIN: `o_start`=1, enables all 0. Counts DRAIN_CYCLES cycles, then goes to FINISH.
  - FINISH: `o_start`=0, `o_run_done`=1 for this one cycle, then back to IDLE.
- PE k finishes at any INJECT edge where `o_enable_send[k]`=1 and `i_pe_done[k]`=1. At that edge set `finished[k]` and clear enable[k]. A PE's `done` is forced high whenever its enable is low, so `i_pe_done` bits whose enable is low are always ignored.
- Concurrent mode: several PEs may finish on the same edge; all are recorded. Go to DRAIN at the edge where `finished` becomes all-ones.
- Serial mode: when the active PE k finishes and k < N-1, enable[k+1] rises at the same edge and `o_active_pe` = k+1. When k = N-1, go to DRAIN.
- Timeout: with TIMEOUT != 0, the edge that would make `o_cycle_count` equal TIMEOUT while the run is unfinished sets `o_timeout`, clears all enables and goes to DRAIN. If completion and timeout land on the same edge, completion wins and `o_timeout` stays 0.
- `i_go` is ignored outside IDLE. `i_mode` is ignored except at the accepting edge.
- `o_cycle_count` and `o_timeout` hold their values through IDLE until the next accepted `i_go`.

## Timing
- `i_go` accepted at edge t: `o_start` and the enables are high from t+1, and `o_cycle_count`=1 after edge t+1.
- Last finish at edge e: enables low from e+1. `o_start` stays high for cycles e+1 .. e+DRAIN_CYCLES. FINISH is cycle e+DRAIN_CYCLES+1, with `o_start`=0 and `o_run_done`=1. `o_busy` falls after that cycle.
- Serial handoff costs zero idle cycles; the next PE is enabled on the edge where the previous one finishes.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Concurrent run: X=Y=2, DRAIN_CYCLES=4, each PE raises `done` 10 cycles after enable. Required: enables=4'b1111 for 10 cycles, then 4'b0000; `o_start` high for 10+4 cycles; one `o_run_done` pulse; `o_cycle_count`=10.
- Serial run, same setup, with `i_mode`=1. Required: enables step 0001→0010→0100→1000, 10 cycles each with no gaps; `o_active_pe` counts 0..3; `o_cycle_count`=40.
- Timeout: TIMEOUT=20, PE 2 never raises `done`. Required: at cycle 20 all enables drop and `o_timeout`=1; drain and FINISH still occur; `o_timeout` is still 1 in IDLE and is cleared by the next `i_go`.
- Same-edge timeout and completion: last `done` arrives exactly at the TIMEOUT edge. Required: `o_timeout`=0 and a normal FINISH.
- Masking and go-ignore: hold `i_pe_done`=all-ones while in IDLE, and pulse `i_go` during INJECT. Required: nothing is finished before the enables rise, and the mid-run `i_go` has no effect.
- Reset mid-DRAIN: drive `rstn` low between clock edges. Required: all outputs are 0 immediately, with no edge needed; the next `i_go` starts a clean run.

Source files
------------

// File: rtl/noc_traffic_sequencer.sv
// Run controller for the mesh traffic-generator PEs: drives start/enableSend,
// collects per-PE done, sequences concurrent or serial injection, drain and finish.
module noc_traffic_sequencer #(
  parameter int unsigned X            = 4,
  parameter int unsigned Y            = 4,
  parameter int unsigned PE_W         = 4,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned DRAIN_CYCLES = 100,
  parameter int unsigned TIMEOUT      = 100000
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_go,
  input  logic               i_mode,
  input  logic [X*Y-1:0]     i_pe_done,
  output logic               o_start,
  output logic [X*Y-1:0]     o_enable_send,
  output logic               o_busy,
  output logic               o_run_done,
  output logic               o_timeout,
  output logic [PE_W-1:0]    o_active_pe,
  output logic [CNT_W-1:0]   o_cycle_count
);

  localparam int unsigned N       = X * Y;
  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_V  = CNT_W'(TIMEOUT);
  localparam bit                 TO_EN      = (TIMEOUT != 0);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] INJECT = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  logic [1:0]         state_r, state_s;
  logic               mode_r, mode_s;
  logic [N-1:0]       finished_r, finished_s;
  logic [N-1:0]       fin_now_s, handoff_s, enable_s;
  logic [DRAIN_W-1:0] drain_cnt_r, drain_cnt_s;
  logic [PE_W-1:0]    active_s;
  logic [CNT_W-1:0]   count_s, count_inc_s;
  logic               timeout_s;

  // Next-state and next-output computation for the run sequencer.
  always_comb begin
    state_s     = state_r;
    mode_s      = mode_r;
    finished_s  = finished_r;
    enable_s    = o_enable_send;
    drain_cnt_s = drain_cnt_r;
    active_s    = o_active_pe;
    count_s     = o_cycle_count;
    timeout_s   = o_timeout;
    // done is forced high by PEs whose enable is low, so only enabled bits count
    fin_now_s   = o_enable_send & i_pe_done;
    handoff_s   = mode_r ? (fin_now_s << 1) : {N{1'b0}};
    if (o_cycle_count == {CNT_W{1'b1}}) begin
      count_inc_s = o_cycle_count;
    end else begin
      count_inc_s = o_cycle_count + CNT_W'(1'b1);
    end

    case (state_r)
      IDLE: begin
        if (i_go) begin
          state_s    = INJECT;
          mode_s     = i_mode;
          finished_s = {N{1'b0}};
          count_s    = {CNT_W{1'b0}};
          timeout_s  = 1'b0;
          active_s   = {PE_W{1'b0}};
          enable_s   = i_mode ? {{(N-1){1'b0}}, 1'b1} : {N{1'b1}};
        end else begin
          enable_s   = {N{1'b0}};
        end
      end
      INJECT: begin
        count_s    = count_inc_s;
        finished_s = finished_r | fin_now_s;
        // serial handoff: next PE enabled on the same edge the active one finishes
        enable_s   = (o_enable_send & ~fin_now_s) | handoff_s;
        if (mode_r && (|fin_now_s) && (o_active_pe != PE_W'(N - 1))) begin
          active_s = o_active_pe + PE_W'(1'b1);
        end else begin
          active_s = o_active_pe;
        end
        // completion takes priority over a timeout landing on the same edge
        if (&finished_s) begin
          state_s     = DRAIN;
          enable_s    = {N{1'b0}};
          drain_cnt_s = {DRAIN_W{1'b0}};
        end else if (TO_EN && (count_inc_s == TIMEOUT_V)) begin
          state_s     = DRAIN;
          enable_s    = {N{1'b0}};
          timeout_s   = 1'b1;
          drain_cnt_s = {DRAIN_W{1'b0}};
        end else begin
          state_s     = INJECT;
        end
      end
      DRAIN: begin
        enable_s = {N{1'b0}};
        if (drain_cnt_r == DRAIN_LAST) begin
          state_s     = FINISH;
          drain_cnt_s = {DRAIN_W{1'b0}};
        end else begin
          drain_cnt_s = drain_cnt_r + DRAIN_W'(1'b1);
        end
      end
      FINISH: begin
        state_s  = IDLE;
        enable_s = {N{1'b0}};
      end
      default: begin
        state_s  = IDLE;
        enable_s = {N{1'b0}};
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r       <= IDLE;
      mode_r        <= 1'b0;
      finished_r    <= {N{1'b0}};
      drain_cnt_r   <= {DRAIN_W{1'b0}};
      o_start       <= 1'b0;
      o_enable_send <= {N{1'b0}};
      o_busy        <= 1'b0;
      o_run_done    <= 1'b0;
      o_timeout     <= 1'b0;
      o_active_pe   <= {PE_W{1'b0}};
      o_cycle_count <= {CNT_W{1'b0}};
    end else begin
      state_r       <= state_s;
      mode_r        <= mode_s;
      finished_r    <= finished_s;
      drain_cnt_r   <= drain_cnt_s;
      o_start       <= (state_s == INJECT) || (state_s == DRAIN);
      o_enable_send <= enable_s;
      o_busy        <= (state_s != IDLE);
      o_run_done    <= (state_s == FINISH);
      o_timeout     <= timeout_s;
      o_active_pe   <= active_s;
      o_cycle_count <= count_s;
    end
  end

endmodule

// File: tb/tb_noc_traffic_sequencer.sv
// Directed bench for noc_traffic_sequencer: 2x2 mesh, drain 4, one instance
// without timeout and one with TIMEOUT=20, driven by a small PE latency model.
module tb_noc_traffic_sequencer;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  logic        go_a = 1'b0, mode_a = 1'b0, go_b = 1'b0, mode_b = 1'b0;
  logic [3:0]  done_a, done_b, en_a, en_b, act_a, act_b;
  logic        start_a, busy_a, rd_a, to_a, start_b, busy_b, rd_b, to_b;
  logic [31:0] cc_a, cc_b;

  noc_traffic_sequencer #(.X(2), .Y(2), .PE_W(4), .CNT_W(32), .DRAIN_CYCLES(4), .TIMEOUT(0)) dut_a (
    .clk(clk), .rstn(rstn), .i_go(go_a), .i_mode(mode_a), .i_pe_done(done_a),
    .o_start(start_a), .o_enable_send(en_a), .o_busy(busy_a), .o_run_done(rd_a),
    .o_timeout(to_a), .o_active_pe(act_a), .o_cycle_count(cc_a));

  noc_traffic_sequencer #(.X(2), .Y(2), .PE_W(4), .CNT_W(32), .DRAIN_CYCLES(4), .TIMEOUT(20)) dut_b (
    .clk(clk), .rstn(rstn), .i_go(go_b), .i_mode(mode_b), .i_pe_done(done_b),
    .o_start(start_b), .o_enable_send(en_b), .o_busy(busy_b), .o_run_done(rd_b),
    .o_timeout(to_b), .o_active_pe(act_b), .o_cycle_count(cc_b));

  // PE model: done rises lat-1 cycles after enable (0 = never); forced high when disabled
  int lat_a [4] = '{10, 10, 10, 10};
  int lat_b [4] = '{10, 10, 10, 10};
  int cnt_a [4] = '{0, 0, 0, 0};
  int cnt_b [4] = '{0, 0, 0, 0};

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      cnt_a[k] <= en_a[k] ? cnt_a[k] + 1 : 0;
      cnt_b[k] <= en_b[k] ? cnt_b[k] + 1 : 0;
    end
  end

  always_comb begin
    done_a = 4'b0000;
    done_b = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      done_a[k] = !en_a[k] || (lat_a[k] != 0 && cnt_a[k] >= lat_a[k] - 1);
      done_b[k] = !en_b[k] || (lat_b[k] != 0 && cnt_b[k] >= lat_b[k] - 1);
    end
  end

  logic        sel = 1'b0;
  logic        m_start, m_busy, m_rd, m_to;
  logic [3:0]  m_en, m_act;
  logic [31:0] m_cc;
  always_comb begin
    m_start = sel ? start_b : start_a;
    m_busy  = sel ? busy_b  : busy_a;
    m_rd    = sel ? rd_b    : rd_a;
    m_to    = sel ? to_b    : to_a;
    m_en    = sel ? en_b    : en_a;
    m_act   = sel ? act_b   : act_a;
    m_cc    = sel ? cc_b    : cc_a;
  end

  int checks = 0;
  int errors = 0;

  logic [3:0]  h_en    [0:511];
  logic [3:0]  h_act   [0:511];
  logic        h_start [0:511];
  logic        h_rd    [0:511];
  logic        h_to    [0:511];
  logic [31:0] h_cc    [0:511];
  int          len;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a run on the selected instance and record every cycle until busy falls.
  task automatic run(input logic use_b, input logic mode, input int mid_go_s);
    int s;
    sel = use_b;
    if (use_b) begin go_b = 1'b1; mode_b = mode; end
    else       begin go_a = 1'b1; mode_a = mode; end
    tick();
    go_a = 1'b0; go_b = 1'b0;
    mode_a = ~mode; mode_b = ~mode;
    s = 1;
    len = -1;
    while (s <= 500) begin
      h_en[s] = m_en; h_act[s] = m_act; h_start[s] = m_start;
      h_rd[s] = m_rd; h_to[s] = m_to; h_cc[s] = m_cc;
      if (!m_busy) begin
        len = s - 1;
        break;
      end
      if (use_b) go_b = (s == mid_go_s);
      else       go_a = (s == mid_go_s);
      tick();
      s++;
    end
    go_a = 1'b0; go_b = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({start_a, en_a, busy_a, rd_a, to_a, act_a, cc_a} !== 44'd0) begin
      errors++;
      $display("FAIL reset_a got start=%b en=%b busy=%b rd=%b to=%b act=%0d cc=%0d want all 0",
               start_a, en_a, busy_a, rd_a, to_a, act_a, cc_a);
    end
    checks++;
    if ({start_b, en_b, busy_b, rd_b, to_b, act_b, cc_b} !== 44'd0) begin
      errors++;
      $display("FAIL reset_b got start=%b en=%b busy=%b rd=%b to=%b act=%0d cc=%0d want all 0",
               start_b, en_b, busy_b, rd_b, to_b, act_b, cc_b);
    end
  endtask

  task automatic test_concurrent(input int mid_go_s);
    logic [3:0] exp_en;
    for (int k = 0; k < 4; k++) lat_a[k] = 10;
    run(1'b0, 1'b0, mid_go_s);
    checks++;
    if (len !== 15) begin errors++; $display("FAIL conc_len got %0d want 15", len); end
    for (int s = 1; s <= 15; s++) begin
      exp_en = (s <= 10) ? 4'b1111 : 4'b0000;
      checks++;
      if ({h_en[s], h_start[s], h_rd[s], h_act[s]} !== {exp_en, (s <= 14), (s == 15), 4'd0}) begin
        errors++;
        $display("FAIL conc_trace s=%0d got en=%b start=%b rd=%b act=%0d want en=%b start=%b rd=%b act=0",
                 s, h_en[s], h_start[s], h_rd[s], h_act[s], exp_en, (s <= 14), (s == 15));
      end
    end
    checks++;
    if (h_cc[2] !== 32'd1) begin errors++; $display("FAIL conc_first_count got %0d want 1", h_cc[2]); end
    checks++;
    if (cc_a !== 32'd10) begin errors++; $display("FAIL conc_count got %0d want 10", cc_a); end
  endtask

  task automatic test_serial();
    logic [3:0] exp_en;
    logic [3:0] exp_act;
    for (int k = 0; k < 4; k++) lat_a[k] = 10;
    run(1'b0, 1'b1, 0);
    checks++;
    if (len !== 45) begin errors++; $display("FAIL ser_len got %0d want 45", len); end
    for (int s = 1; s <= 45; s++) begin
      exp_en  = (s <= 40) ? (4'b0001 << ((s - 1) / 10)) : 4'b0000;
      exp_act = (s <= 40) ? 4'((s - 1) / 10) : h_act[s];
      checks++;
      if ({h_en[s], h_act[s], h_start[s], h_rd[s]} !== {exp_en, exp_act, (s <= 44), (s == 45)}) begin
        errors++;
        $display("FAIL ser_trace s=%0d got en=%b act=%0d start=%b rd=%b want en=%b act=%0d start=%b rd=%b",
                 s, h_en[s], h_act[s], h_start[s], h_rd[s], exp_en, exp_act, (s <= 44), (s == 45));
      end
    end
    checks++;
    if (cc_a !== 32'd40) begin errors++; $display("FAIL ser_count got %0d want 40", cc_a); end
  endtask

  task automatic test_timeout();
    logic [3:0] exp_en;
    lat_b[0] = 10; lat_b[1] = 10; lat_b[2] = 0; lat_b[3] = 10;
    run(1'b1, 1'b0, 0);
    checks++;
    if (len !== 25) begin errors++; $display("FAIL to_len got %0d want 25", len); end
    for (int s = 1; s <= 25; s++) begin
      exp_en = (s <= 10) ? 4'b1111 : ((s <= 20) ? 4'b0100 : 4'b0000);
      checks++;
      if ({h_en[s], h_to[s], h_start[s], h_rd[s]} !== {exp_en, (s >= 21), (s <= 24), (s == 25)}) begin
        errors++;
        $display("FAIL to_trace s=%0d got en=%b to=%b start=%b rd=%b want en=%b to=%b start=%b rd=%b",
                 s, h_en[s], h_to[s], h_start[s], h_rd[s], exp_en, (s >= 21), (s <= 24), (s == 25));
      end
    end
    repeat (3) tick();
    checks++;
    if ({to_b, busy_b, cc_b} !== {1'b1, 1'b0, 32'd20}) begin
      errors++;
      $display("FAIL to_idle_hold got to=%b busy=%b cc=%0d want to=1 busy=0 cc=20", to_b, busy_b, cc_b);
    end
  endtask

  task automatic test_same_edge();
    logic [3:0] exp_en;
    lat_b[0] = 5; lat_b[1] = 5; lat_b[2] = 5; lat_b[3] = 20;
    run(1'b1, 1'b0, 0);
    checks++;
    if ({h_to[1], h_cc[1]} !== {1'b0, 32'd0}) begin
      errors++;
      $display("FAIL go_clears got to=%b cc=%0d want to=0 cc=0", h_to[1], h_cc[1]);
    end
    checks++;
    if (len !== 25) begin errors++; $display("FAIL same_len got %0d want 25", len); end
    for (int s = 1; s <= 25; s++) begin
      exp_en = (s <= 5) ? 4'b1111 : ((s <= 20) ? 4'b1000 : 4'b0000);
      checks++;
      if ({h_en[s], h_to[s], h_start[s], h_rd[s]} !== {exp_en, 1'b0, (s <= 24), (s == 25)}) begin
        errors++;
        $display("FAIL same_trace s=%0d got en=%b to=%b start=%b rd=%b want en=%b to=0 start=%b rd=%b",
                 s, h_en[s], h_to[s], h_start[s], h_rd[s], exp_en, (s <= 24), (s == 25));
      end
    end
    checks++;
    if ({to_b, cc_b} !== {1'b0, 32'd20}) begin
      errors++;
      $display("FAIL same_final got to=%b cc=%0d want to=0 cc=20", to_b, cc_b);
    end
  endtask

  task automatic test_mask_go();
    repeat (3) tick();
    checks++;
    if ({busy_a, en_a, start_a, done_a} !== {1'b0, 4'b0000, 1'b0, 4'b1111}) begin
      errors++;
      $display("FAIL mask_idle got busy=%b en=%b start=%b done=%b want busy=0 en=0000 start=0 done=1111",
               busy_a, en_a, start_a, done_a);
    end
    test_concurrent(4);
    repeat (3) tick();
    checks++;
    if ({busy_a, start_a} !== 2'b00) begin
      errors++;
      $display("FAIL go_ignored got busy=%b start=%b want 0 0", busy_a, start_a);
    end
  endtask

  task automatic test_reset_mid_drain();
    for (int k = 0; k < 4; k++) lat_a[k] = 10;
    go_a = 1'b1; mode_a = 1'b0;
    tick();
    go_a = 1'b0;
    repeat (11) tick();
    checks++;
    if ({start_a, en_a, busy_a} !== {1'b1, 4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL in_drain got start=%b en=%b busy=%b want 1 0000 1", start_a, en_a, busy_a);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({start_a, en_a, busy_a, rd_a, to_a, act_a, cc_a} !== 44'd0) begin
      errors++;
      $display("FAIL async_reset got start=%b en=%b busy=%b rd=%b to=%b act=%0d cc=%0d want all 0",
               start_a, en_a, busy_a, rd_a, to_a, act_a, cc_a);
    end
    @(negedge clk) rstn = 1'b1;
    tick();
    test_concurrent(0);
  endtask

  initial begin
    #2 rstn = 1'b0;
    #1;
    test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    tick();
    test_concurrent(0);
    test_serial();
    test_timeout();
    test_same_edge();
    test_mask_go();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
